// File: rtl/nexys_starship_spawn_sched_if.sv
// Spawn scheduler bus: game control, per-direction requests and clears,
// registered spawn pulses and occupancy status.
interface nexys_starship_spawn_sched_if;
  logic       game_en;
  logic       top_random;
  logic       btm_random;
  logic       left_random;
  logic       right_random;
  logic       top_clear;
  logic       btm_clear;
  logic       left_clear;
  logic       right_clear;
  logic       top_spawn;
  logic       btm_spawn;
  logic       left_spawn;
  logic       right_spawn;
  logic [3:0] active;
  logic [2:0] active_count;
  logic       cooling;

  modport master (
    output game_en,
    output top_random, btm_random,
    output left_random, right_random,
    output top_clear, btm_clear,
    output left_clear, right_clear,
    input  top_spawn, btm_spawn,
    input  left_spawn, right_spawn,
    input  active, active_count, cooling
  );

  modport slave (
    input  game_en,
    input  top_random, btm_random,
    input  left_random, right_random,
    input  top_clear, btm_clear,
    input  left_clear, right_clear,
    output top_spawn, btm_spawn,
    output left_spawn, right_spawn,
    output active, active_count, cooling
  );
endinterface

// File: rtl/nexys_starship_spawn_sched.sv
// Monster spawn scheduler: sticky per-direction requests, round-robin
// grant under an active-population cap, fixed cooldown between spawns.
module nexys_starship_spawn_sched #(
  parameter int COOLDOWN   = 16,
  parameter int MAX_ACTIVE = 2
) (
  input logic Clk,
  input logic Reset_n,
  nexys_starship_spawn_sched_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    COOL
  } state_t;

  localparam logic [7:0] CD_LOAD = 8'(COOLDOWN - 1);
  localparam logic [2:0] CAP     = 3'(MAX_ACTIVE);

  state_t     state, state_nx;
  logic [3:0] pending, pending_nx;
  logic [3:0] act, act_nx;
  logic [3:0] spawn, grant;
  logic [2:0] count;
  logic [1:0] ptr, ptr_nx;
  logic [7:0] cnt, cnt_nx;
  logic [3:0] rnd, clr, elig;
  logic [1:0] idx;
  logic       found;

  function automatic logic [2:0] pop4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

  assign rnd = {bus.right_random, bus.left_random,
                bus.btm_random, bus.top_random};
  assign clr = {bus.right_clear, bus.left_clear,
                bus.btm_clear, bus.top_clear};

  assign elig  = (pending | rnd) & ~act & ~clr;
  assign found = |elig;

  // Descending scan: the smallest offset from ptr wins.
  always_comb begin
    idx = ptr;
    for (int i = 3; i >= 0; i--) begin
      if (elig[ptr + 2'(i)]) idx = ptr + 2'(i);
    end
  end

  always_comb begin
    state_nx   = state;
    pending_nx = pending;
    act_nx     = act;
    ptr_nx     = ptr;
    cnt_nx     = cnt;
    grant      = '0;
    if (!bus.game_en) begin
      state_nx   = IDLE;
      pending_nx = '0;
      act_nx     = '0;
      ptr_nx     = '0;
      cnt_nx     = '0;
    end else begin
      unique case (state)
        IDLE: state_nx = ARMED;
        ARMED: begin
          pending_nx = pending | (rnd & ~act);
          act_nx     = act & ~clr;
          if (found && count < CAP) begin
            grant      = 4'b0001 << idx;
            pending_nx = pending_nx & ~grant;
            act_nx     = act_nx | grant;
            ptr_nx     = idx + 2'd1;
            cnt_nx     = CD_LOAD;
            state_nx   = COOL;
          end
        end
        COOL: begin
          pending_nx = pending | (rnd & ~act);
          act_nx     = act & ~clr;
          if (cnt == 8'd0) begin
            state_nx = ARMED;
          end else begin
            cnt_nx = cnt - 8'd1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= IDLE;
      pending <= '0;
      act     <= '0;
      count   <= '0;
      spawn   <= '0;
      ptr     <= '0;
      cnt     <= '0;
    end else begin
      state   <= state_nx;
      pending <= pending_nx;
      act     <= act_nx;
      count   <= pop4(act_nx);
      spawn   <= grant;
      ptr     <= ptr_nx;
      cnt     <= cnt_nx;
    end
  end

  assign bus.top_spawn    = spawn[0];
  assign bus.btm_spawn    = spawn[1];
  assign bus.left_spawn   = spawn[2];
  assign bus.right_spawn  = spawn[3];
  assign bus.active       = act;
  assign bus.active_count = count;
  assign bus.cooling      = (state == COOL);
endmodule

// File: tb/tb_nexys_starship_spawn_sched.sv
// Bench for the spawn scheduler: directed scenarios plus random traffic,
// all compared every cycle against a queue-free behavioural model.
module tb_nexys_starship_spawn_sched;
  localparam int CD  = 4;
  localparam int MAXA = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  nexys_starship_spawn_sched_if bus ();

  nexys_starship_spawn_sched #(
    .COOLDOWN  (CD),
    .MAX_ACTIVE(MAXA)
  ) dut (
    .Clk    (clk),
    .Reset_n(rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Model: mode 0 idle, 1 armed, 2 cooling; cool_left = cycles still to cool
  logic [3:0] m_pend = '0;
  logic [3:0] m_act = '0;
  logic [3:0] m_spawn = '0;
  int         m_mode = 0;
  int         m_ptr = 0;
  int         m_cool = 0;

  function automatic logic [3:0] spawn_vec();
    return {bus.right_spawn, bus.left_spawn, bus.btm_spawn, bus.top_spawn};
  endfunction

  task automatic chk(input string name, input logic [7:0] got,
                     input logic [7:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, got, want, $time);
    end
  endtask

  task automatic model_step();
    logic [3:0] r, c, el;
    int g;
    r = {bus.right_random, bus.left_random, bus.btm_random, bus.top_random};
    c = {bus.right_clear, bus.left_clear, bus.btm_clear, bus.top_clear};
    m_spawn = '0;
    if (!bus.game_en) begin
      m_mode = 0; m_pend = '0; m_act = '0; m_ptr = 0; m_cool = 0;
      return;
    end
    if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      el = (m_pend | r) & ~m_act & ~c;
      g = -1;
      if ($countones(m_act) < MAXA)
        for (int k = 0; k < 4; k++)
          if (g < 0 && el[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
      m_pend = m_pend | (r & ~m_act);
      m_act = m_act & ~c;
      if (g >= 0) begin
        m_pend[g] = 1'b0;
        m_act[g] = 1'b1;
        m_spawn[g] = 1'b1;
        m_ptr = (g + 1) % 4;
        m_cool = CD;
        m_mode = 2;
      end
    end else begin
      m_pend = m_pend | (r & ~m_act);
      m_act = m_act & ~c;
      m_cool--;
      if (m_cool == 0) m_mode = 1;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_pend = '0; m_act = '0; m_spawn = '0;
      m_ptr = 0; m_cool = 0;
    end else begin
      model_step();
    end
  end

  always @(posedge clk) begin
    #2;
    chk("spawn", {4'b0, spawn_vec()}, {4'b0, m_spawn});
    chk("active", {4'b0, bus.active}, {4'b0, m_act});
    chk("active_count", {5'b0, bus.active_count},
        8'($countones(m_act)));
    chk("cooling", {7'b0, bus.cooling}, {7'b0, m_mode == 2});
  end

  task automatic set_rnd(input logic [3:0] v);
    bus.top_random = v[0]; bus.btm_random = v[1];
    bus.left_random = v[2]; bus.right_random = v[3];
  endtask

  task automatic set_clr(input logic [3:0] v);
    bus.top_clear = v[0]; bus.btm_clear = v[1];
    bus.left_clear = v[2]; bus.right_clear = v[3];
  endtask

  task automatic quiet();
    set_rnd(4'b0);
    set_clr(4'b0);
  endtask

  task automatic wait_spawn(input string name, input int want);
    logic [3:0] s;
    int idx;
    idx = -1;
    for (int n = 0; n < 40 && idx < 0; n++) begin
      @(negedge clk);
      quiet();
      s = spawn_vec();
      for (int d = 0; d < 4; d++) if (s[d]) idx = d;
    end
    checks++;
    if (idx != want) begin
      failures++;
      $display("FAIL %s got_dir=%0d want_dir=%0d", name, idx, want);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.game_en = 1'b0;
    quiet();
    repeat (3) @(negedge clk);
    chk("rst_active", {4'b0, bus.active}, 8'h00);
    chk("rst_count", {5'b0, bus.active_count}, 8'h00);
    chk("rst_cooling", {7'b0, bus.cooling}, 8'h00);
    chk("rst_spawn", {4'b0, spawn_vec()}, 8'h00);

    // basic spawn and cooldown length
    rst_n = 1'b1;
    bus.game_en = 1'b1;
    @(negedge clk);
    set_rnd(4'b0001);
    @(negedge clk);
    quiet();
    chk("basic_top_spawn", {7'b0, bus.top_spawn}, 8'h01);
    chk("basic_active", {4'b0, bus.active}, 8'h01);
    chk("basic_cool0", {7'b0, bus.cooling}, 8'h01);
    for (int i = 1; i < CD; i++) begin
      @(negedge clk);
      chk("basic_cool_hold", {7'b0, bus.cooling}, 8'h01);
    end
    @(negedge clk);
    chk("basic_cool_end", {7'b0, bus.cooling}, 8'h00);

    // capacity limit holds left pending until top clears
    set_rnd(4'b0010);
    wait_spawn("cap_btm", 1);
    repeat (5) @(negedge clk);
    set_rnd(4'b0100);
    @(negedge clk);
    quiet();
    repeat (3) @(negedge clk);
    chk("cap_full_active", {4'b0, bus.active}, 8'h03);
    chk("cap_no_spawn", {4'b0, spawn_vec()}, 8'h00);
    set_clr(4'b0001);
    @(negedge clk);
    quiet();
    chk("cap_after_clear", {4'b0, bus.active}, 8'h02);
    @(negedge clk);
    chk("cap_left_spawn", {7'b0, bus.left_spawn}, 8'h01);
    chk("cap_left_active", {4'b0, bus.active}, 8'h06);

    // clear and request for the same active direction
    repeat (5) @(negedge clk);
    set_clr(4'b0010);
    @(negedge clk);
    quiet();
    set_rnd(4'b0001);
    wait_spawn("same_top_grant", 0);
    repeat (5) @(negedge clk);
    set_clr(4'b0001);
    set_rnd(4'b0001);
    @(negedge clk);
    quiet();
    chk("same_no_spawn", {7'b0, bus.top_spawn}, 8'h00);
    chk("same_cleared", {4'b0, bus.active}, 8'h04);
    repeat (6) @(negedge clk);
    chk("same_dropped", {4'b0, bus.active}, 8'h04);

    // game_en drop in COOL with right and btm pending
    set_rnd(4'b1000);
    wait_spawn("drop_right", 3);
    set_clr(4'b1100);
    @(negedge clk);
    quiet();
    set_rnd(4'b1010);
    @(negedge clk);
    quiet();
    chk("drop_in_cool", {7'b0, bus.cooling}, 8'h01);
    bus.game_en = 1'b0;
    @(negedge clk);
    chk("drop_cooling", {7'b0, bus.cooling}, 8'h00);
    chk("drop_active", {4'b0, bus.active}, 8'h00);
    bus.game_en = 1'b1;
    repeat (10) @(negedge clk);
    chk("drop_no_respawn", {5'b0, bus.active_count}, 8'h00);

    // round-robin order from a reset pointer
    set_rnd(4'b1111);
    wait_spawn("rr_0", 0);
    wait_spawn("rr_1", 1);
    set_clr(4'b0011);
    wait_spawn("rr_2", 2);
    wait_spawn("rr_3", 3);
    chk("rr_active", {4'b0, bus.active}, 8'h0c);
    chk("rr_count", {5'b0, bus.active_count}, 8'h02);

    // async reset while left_spawn is high
    repeat (5) @(negedge clk);
    set_clr(4'b1111);
    @(negedge clk);
    quiet();
    set_rnd(4'b0100);
    wait_spawn("arst_left", 2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_spawn", {7'b0, bus.left_spawn}, 8'h00);
    chk("arst_active", {4'b0, bus.active}, 8'h00);
    chk("arst_count", {5'b0, bus.active_count}, 8'h00);
    chk("arst_cooling", {7'b0, bus.cooling}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      bus.game_en = ($urandom_range(0, 59) != 0);
      for (int d = 0; d < 4; d++) begin
        logic [3:0] r, c;
        r = {bus.right_random, bus.left_random,
             bus.btm_random, bus.top_random};
        c = {bus.right_clear, bus.left_clear,
             bus.btm_clear, bus.top_clear};
        r[d] = ($urandom_range(0, 5) == 0);
        c[d] = ($urandom_range(0, 7) == 0);
        set_rnd(r);
        set_clr(c);
      end
      if ($urandom_range(0, 499) == 0) begin
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/nexys_starship_spawn_sched.md
NEXYS_STARSHIP_SPAWN_SCHED -- requirements
Module: nexys_starship_spawn_sched

Interface
REQ-001 SHALL have parameter COOLDOWN, default 16: minimum number of cycles in COOL after each spawn before the next grant; legal range 1..255.
REQ-002 SHALL have parameter MAX_ACTIVE, default 2: maximum number of simultaneously active directions; legal range 1..4.
REQ-003 SHALL have port Clk  in  1  single system clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset_n  in  1  reset; asynchronous, active-low.
REQ-005 SHALL have port game_en  in  1  high while a game is running; low forces IDLE.
REQ-006 SHALL have ports top_random, btm_random, left_random, right_random  in  1 each  spawn-request pulses from the PRNG block.
REQ-007 SHALL have ports top_clear, btm_clear, left_clear, right_clear  in  1 each  monster-defeated pulses per direction.
REQ-008 SHALL have ports top_spawn, btm_spawn, left_spawn, right_spawn  out  1 each  registered one-cycle spawn pulses.
REQ-009 SHALL have port active  out  4  registered per-direction active flags; bit order {right, left, btm, top}, with top at bit 0.
REQ-010 SHALL have port active_count  out  3  registered population count of active (0..4).
REQ-011 SHALL have port cooling  out  1  registered; high while in state COOL.

Function
REQ-012 SHALL implement three states: IDLE, ARMED, COOL.
REQ-013 IDLE->ARMED on a clock edge with game_en=1; any state->IDLE on an edge with game_en=0, clearing pending, active, the cooldown counter and the round-robin pointer.
REQ-014 SHALL hold a 4-bit sticky pending register; at each edge, in ARMED or COOL, pending |= (random inputs & ~active), and random inputs for already-active directions are discarded.
REQ-015 Eligible set = (pending | current random inputs) & ~active & ~clear inputs; a direction whose clear pulse is present in the same cycle is not eligible in that cycle.
REQ-016 In ARMED, at an edge where the eligible set is nonzero and active_count < MAX_ACTIVE, SHALL grant exactly one direction: round-robin starting at the pointer, in order top, btm, left, right, wrapping right->top.
REQ-017 On a grant, SHALL, at that edge: assert the matching *_spawn for exactly the following cycle; set its active bit; clear its pending bit; set the pointer to the granted index +1 mod 4; load the counter with COOLDOWN-1; and enter COOL.
REQ-018 Latency: a random pulse sampled at edge N with ARMED and capacity available SHALL produce the spawn pulse during cycle N+1.
REQ-019 COOL SHALL decrement the counter by 1 each edge and go to ARMED at the edge where the counter is 0; COOL therefore lasts exactly COOLDOWN cycles, and no grant occurs in COOL.
REQ-020 A *_clear pulse SHALL clear the matching active bit at that edge in any state except IDLE; a clear for an inactive direction has no effect.
REQ-021 A clear and a grant at the same edge SHALL both take effect; active_count reflects both, and net change may be 0.
REQ-022 When active_count = MAX_ACTIVE, eligible requests SHALL remain pending, with no loss, until capacity frees.
REQ-023 active_count SHALL always equal popcount(active); at most one *_spawn SHALL be high in any cycle.
REQ-024 The counter SHALL be 8 bits wide, unsigned, and SHALL never wrap below 0.

Reset
REQ-025 While Reset_n=0: state=IDLE, pending=0, active=0, active_count=0, all *_spawn=0, cooling=0, pointer=top, counter=0.
REQ-026 Reset assertion mid-COOL or mid-spawn-pulse SHALL clear all outputs immediately (asynchronously); after release, operation SHALL resume from IDLE.

Verification
REQ-027 Basic spawn (COOLDOWN=4): reset, game_en=1, top_random pulse at edge 3 -> top_spawn high in cycle 4; active=0001; cooling high for 4 cycles; then ARMED.
REQ-028 Round-robin: all four random inputs pulse together in ARMED, MAX_ACTIVE=4, COOLDOWN=1 -> spawns in order top, btm, left, right, spaced 2 cycles apart; active=1111; active_count=4.
REQ-029 Capacity limit (MAX_ACTIVE=2): after top and btm are active, left_random pulses -> no spawn; top_clear pulses -> left_spawn in the cycle after the edge where the clear is seen in ARMED; active=0110.
REQ-030 Simultaneous clear and request: top active, top_clear and top_random in the same cycle -> top not granted that edge and the request dropped; active bit 0 = 0.
REQ-031 game_en drop in COOL with pending=1010 -> next edge IDLE, pending=0, active=0, cooling=0; re-enable -> no spawn until a new random pulse.
REQ-032 Async reset mid-pulse: Reset_n low during the left_spawn high cycle -> left_spawn, active, active_count and cooling all 0 before the next edge.
